// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store controller.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] LT_WORD = 3'b000;
  localparam logic [2:0] LT_BU   = 3'b001;
  localparam logic [2:0] LT_BS   = 3'b010;
  localparam logic [2:0] LT_HU   = 3'b100;
  localparam logic [2:0] LT_HS   = 3'b101;

  localparam logic [1:0] ST_WORD = 2'b00;
  localparam logic [1:0] ST_BYTE = 2'b01;
  localparam logic [1:0] ST_HALF = 2'b10;

  localparam int CNT_W = 16;

  function automatic logic legal_load(input logic [2:0] lt);
    return (lt == LT_WORD) || (lt == LT_BU) || (lt == LT_BS) ||
           (lt == LT_HU) || (lt == LT_HS);
  endfunction

  function automatic logic legal_store(input logic [1:0] st);
    return st != 2'b11;
  endfunction

  // An access needs two beats when its bytes straddle a word boundary.
  function automatic logic needs_split(input logic is_load, input logic [2:0] lt,
                                       input logic [1:0] st, input logic [1:0] off);
    logic is_word;
    logic is_half;
    is_word = is_load ? (lt == LT_WORD) : (st == ST_WORD);
    is_half = is_load ? lt[2] : (st == ST_HALF);
    return (is_word && (off != 2'd0)) || (is_half && (off == 2'd3));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane shifting: store data/byte-enable placement and load merge/extend.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the controller decides when results are used.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_st_off,
  input  logic [1:0]  i_st_type,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_wdata64,
  output logic [7:0]  o_be8,
  input  logic [1:0]  i_ld_off,
  input  logic [2:0]  i_ld_type,
  input  logic [31:0] i_rdata0,
  input  logic [31:0] i_rdata1,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_mask;
  logic [31:0] w_shifted;

  // Store side: place the right-aligned data and its byte mask at the byte offset;
  // the low half feeds beat 0 and the high half feeds beat 1.
  always_comb begin
    w_mask = 8'h0F;
    case (i_st_type)
      ST_BYTE: w_mask = 8'h01;
      ST_HALF: w_mask = 8'h03;
      default: w_mask = 8'h0F;
    endcase
    o_be8     = w_mask << i_st_off;
    o_wdata64 = {32'd0, i_wdata} << {i_st_off, 3'b000};
  end

  // Load side: bring the addressed bytes down to bit 0, then size and extend.
  always_comb begin
    w_shifted = 32'({i_rdata1, i_rdata0} >> {i_ld_off, 3'b000});
    o_ldata   = w_shifted;
    case (i_ld_type)
      LT_BU:   o_ldata = {24'd0, w_shifted[7:0]};
      LT_BS:   o_ldata = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LT_HU:   o_ldata = {16'd0, w_shifted[15:0]};
      LT_HS:   o_ldata = {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: o_ldata = w_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one CPU access at a time as one or two aligned req/ack beats.
// Latency: Done 2 cycles after the request (3 when split) with ack in the first request cycle.
// Backpressure: CPU held by Stall until Done; beats wait on BusAck up to TIMEOUT cycles.
// Build option: define LSU_MISALIGNED_EN to split misaligned accesses; otherwise they fault.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic [31:0] i_Addr,
  input  logic [2:0]  i_LoadType,
  input  logic [1:0]  i_StoreType,
  input  logic [31:0] i_WriteData,
  output logic        o_Stall,
  output logic        o_Done,
  output logic        o_Fault,
  output logic [31:0] o_ReadDataOut,
  output logic        o_BusReq,
  output logic        o_BusWe,
  output logic [31:0] o_BusAddr,
  output logic [3:0]  o_BusBe,
  output logic [31:0] o_BusWData,
  input  logic        i_BusAck,
  input  logic [31:0] i_BusRData
);

  state_t             r_state;
  logic [1:0]         r_off;
  logic               r_is_load;
  logic [2:0]         r_ld_type;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_bus_req;
  logic               r_bus_we;
  logic [31:0]        r_bus_addr;
  logic [3:0]         r_bus_be;
  logic [31:0]        r_bus_wdata;
  logic               r_done;
  logic               r_fault;
  logic [31:0]        r_rdata_out;

  logic               w_req;
  logic               w_illegal;
  logic               w_split;
  logic               w_split_fault;
  logic               w_timeout;
  logic [63:0]        w_wd64;
  logic [7:0]         w_be8;
  logic [31:0]        w_rd0;
  logic [31:0]        w_rd1;
  logic [31:0]        w_ldata;

`ifdef LSU_MISALIGNED_EN
  logic               r_split;
  logic [31:0]        r_wd_hi;
  logic [3:0]         r_be_hi;
  logic [31:0]        r_rdata0;

  // Second beat of a split load merges the saved first word with the live bus word.
  assign w_rd0         = (r_state == S_BEAT1) ? r_rdata0 : i_BusRData;
  assign w_rd1         = (r_state == S_BEAT1) ? i_BusRData : 32'd0;
  assign w_split_fault = 1'b0;
`else
  logic               w_unused_hi;

  assign w_rd0         = i_BusRData;
  assign w_rd1         = 32'd0;
  assign w_split_fault = w_split;
  assign w_unused_hi   = ^{w_wd64[63:32], w_be8[7:4]};
`endif

  assign w_req     = i_MemRead | i_MemWrite;
  assign w_illegal = (i_MemRead & i_MemWrite) |
                     (i_MemRead & ~legal_load(i_LoadType)) |
                     (i_MemWrite & ~legal_store(i_StoreType));
  assign w_split   = needs_split(i_MemRead, i_LoadType, i_StoreType, i_Addr[1:0]);
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Store lanes come from the live request (captured in IDLE); load lanes from the latched access.
  lsu_align u_align (
    .i_st_off  (i_Addr[1:0]),
    .i_st_type (i_StoreType),
    .i_wdata   (i_WriteData),
    .o_wdata64 (w_wd64),
    .o_be8     (w_be8),
    .i_ld_off  (r_off),
    .i_ld_type (r_ld_type),
    .i_rdata0  (w_rd0),
    .i_rdata1  (w_rd1),
    .o_ldata   (w_ldata)
  );

  // Access sequencer: accept, issue beats, watch for ack/timeout, pulse Done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_off       <= 2'd0;
      r_is_load   <= 1'b0;
      r_ld_type   <= 3'd0;
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_be    <= 4'd0;
      r_bus_wdata <= 32'd0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_rdata_out <= 32'd0;
`ifdef LSU_MISALIGNED_EN
      r_split     <= 1'b0;
      r_wd_hi     <= 32'd0;
      r_be_hi     <= 4'd0;
      r_rdata0    <= 32'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done  <= 1'b0;
          r_fault <= 1'b0;
          if (w_req) begin
            r_off     <= i_Addr[1:0];
            r_is_load <= i_MemRead;
            r_ld_type <= i_LoadType;
            r_cnt     <= '0;
            if (w_illegal || w_split_fault) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_fault <= 1'b1;
            end else begin
              r_state     <= S_BEAT0;
              r_bus_req   <= 1'b1;
              r_bus_we    <= i_MemWrite;
              r_bus_addr  <= {i_Addr[31:2], 2'b00};
              r_bus_be    <= i_MemWrite ? w_be8[3:0] : 4'hF;
              r_bus_wdata <= i_MemWrite ? w_wd64[31:0] : 32'd0;
`ifdef LSU_MISALIGNED_EN
              r_split     <= w_split;
              r_be_hi     <= i_MemWrite ? w_be8[7:4] : 4'hF;
              r_wd_hi     <= i_MemWrite ? w_wd64[63:32] : 32'd0;
`endif
            end
          end
        end
`ifdef LSU_MISALIGNED_EN
        S_BEAT0, S_BEAT1: begin
`else
        S_BEAT0: begin
`endif
          if (i_BusAck) begin
            r_cnt <= '0;
`ifdef LSU_MISALIGNED_EN
            if ((r_state == S_BEAT0) && r_split) begin
              r_state     <= S_BEAT1;
              r_bus_addr  <= r_bus_addr + 32'd4;
              r_bus_be    <= r_be_hi;
              r_bus_wdata <= r_wd_hi;
              r_rdata0    <= i_BusRData;
            end else
`endif
            begin
              r_state   <= S_DONE;
              r_bus_req <= 1'b0;
              r_done    <= 1'b1;
              r_fault   <= 1'b0;
              if (r_is_load) r_rdata_out <= w_ldata;
            end
          end else if (w_timeout) begin
            r_state   <= S_DONE;
            r_bus_req <= 1'b0;
            r_done    <= 1'b1;
            r_fault   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_fault <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_Stall       = w_req & ~r_done;
  assign o_Done        = r_done;
  assign o_Fault       = r_fault;
  assign o_ReadDataOut = r_rdata_out;
  assign o_BusReq      = r_bus_req;
  assign o_BusWe       = r_bus_we;
  assign o_BusAddr     = r_bus_addr;
  assign o_BusBe       = r_bus_be;
  assign o_BusWData    = r_bus_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed scoreboard bench for lsu_ctrl (TIMEOUT=4), expectations follow LSU_MISALIGNED_EN.
// Latency: checks Done cycle, beat addresses/enables/data and load results.
// Backpressure: bench acks each beat in its first request cycle, or never for the timeout case.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_MemRead = 1'b0;
  logic        i_MemWrite = 1'b0;
  logic [31:0] i_Addr = 32'd0;
  logic [2:0]  i_LoadType = 3'd0;
  logic [1:0]  i_StoreType = 2'd0;
  logic [31:0] i_WriteData = 32'd0;
  logic        i_BusAck = 1'b0;
  logic [31:0] i_BusRData = 32'd0;
  logic        o_Stall, o_Done, o_Fault, o_BusReq, o_BusWe;
  logic [31:0] o_ReadDataOut, o_BusAddr, o_BusWData;
  logic [3:0]  o_BusBe;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite), .i_Addr(i_Addr),
    .i_LoadType(i_LoadType), .i_StoreType(i_StoreType), .i_WriteData(i_WriteData),
    .o_Stall(o_Stall), .o_Done(o_Done), .o_Fault(o_Fault), .o_ReadDataOut(o_ReadDataOut),
    .o_BusReq(o_BusReq), .o_BusWe(o_BusWe), .o_BusAddr(o_BusAddr), .o_BusBe(o_BusBe),
    .o_BusWData(o_BusWData), .i_BusAck(i_BusAck), .i_BusRData(i_BusRData)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } beat_t;

  typedef struct {
    int          lat;
    logic        fault;
    logic [31:0] rdata;
    int          reqs;
  } res_t;

  beat_t       beat_q[$];
  res_t        res_q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] held = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input logic [31:0] rdata);
    beat_t b;
    b.we = we; b.addr = addr; b.be = be; b.wdata = wdata; b.rdata = rdata;
    beat_q.push_back(b);
  endtask

  task automatic push_res(input int lat, input logic fault, input logic [31:0] rdata, input int reqs);
    res_t r;
    r.lat = lat; r.fault = fault; r.rdata = rdata; r.reqs = reqs;
    res_q.push_back(r);
  endtask

  task automatic run_access(input string tag, input logic mr, input logic mw,
                            input logic [31:0] addr, input logic [2:0] lt, input logic [1:0] st,
                            input logic [31:0] wd, input logic ack_en);
    res_t  r;
    beat_t b;
    int    cyc;
    int    reqs;
    logic  seen;
    @(negedge clk);
    i_MemRead = mr; i_MemWrite = mw; i_Addr = addr;
    i_LoadType = lt; i_StoreType = st; i_WriteData = wd;
    cyc = 0; reqs = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      i_BusAck = 1'b0;
      i_BusRData = 32'd0;
      if (o_Done) begin
        seen = 1'b1;
        r = res_q.pop_front();
        check({tag, ":done_cycle"}, 32'(cyc), 32'(r.lat));
        check({tag, ":fault"}, 32'(o_Fault), 32'(r.fault));
        check({tag, ":rdata"}, o_ReadDataOut, r.rdata);
        check({tag, ":req_cycles"}, 32'(reqs), 32'(r.reqs));
        check({tag, ":req_low_at_done"}, 32'(o_BusReq), 32'd0);
        check({tag, ":stall_at_done"}, 32'(o_Stall), 32'd0);
        check({tag, ":beats_left"}, 32'(beat_q.size()), 32'd0);
        i_MemRead = 1'b0; i_MemWrite = 1'b0;
      end else begin
        if (cyc == 1) check({tag, ":stall"}, 32'(o_Stall), 32'd1);
        if (o_BusReq) begin
          reqs++;
          if (ack_en && beat_q.size() > 0) begin
            b = beat_q.pop_front();
            check({tag, ":bus_we"}, 32'(o_BusWe), 32'(b.we));
            check({tag, ":bus_addr"}, o_BusAddr, b.addr);
            check({tag, ":bus_be"}, 32'(o_BusBe), 32'(b.be));
            if (b.we) check({tag, ":bus_wdata"}, o_BusWData, b.wdata);
            i_BusAck = 1'b1;
            i_BusRData = b.rdata;
          end
        end
      end
    end
    if (!seen) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s:no_done observed=no Done in 40 cycles expected=Done", tag);
      if (res_q.size() > 0) res_q.delete(0);
      beat_q.delete();
      i_MemRead = 1'b0; i_MemWrite = 1'b0; i_BusAck = 1'b0;
    end
    @(negedge clk);
    check({tag, ":done_pulse_ends"}, 32'(o_Done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=simulation still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst:bus_req", 32'(o_BusReq), 32'd0);
    check("rst:bus_addr", o_BusAddr, 32'd0);
    check("rst:bus_be", 32'(o_BusBe), 32'd0);
    check("rst:done", 32'(o_Done), 32'd0);
    check("rst:rdata", o_ReadDataOut, 32'd0);
    check("rst:stall", 32'(o_Stall), 32'd0);
    rst_n = 1'b1;

    // Aligned word load
    push_beat(1'b0, 32'h100, 4'hF, 32'd0, 32'h8899AABB);
    held = 32'h8899AABB; push_res(2, 1'b0, held, 1);
    run_access("lw_100", 1'b1, 1'b0, 32'h100, 3'b000, 2'b00, 32'd0, 1'b1);

    // Byte loads at offset 3, signed then unsigned
    push_beat(1'b0, 32'h200, 4'hF, 32'd0, 32'h80112233);
    held = 32'hFFFFFF80; push_res(2, 1'b0, held, 1);
    run_access("lb_203", 1'b1, 1'b0, 32'h203, 3'b010, 2'b00, 32'd0, 1'b1);
    push_beat(1'b0, 32'h200, 4'hF, 32'd0, 32'h80112233);
    held = 32'h00000080; push_res(2, 1'b0, held, 1);
    run_access("lbu_203", 1'b1, 1'b0, 32'h203, 3'b001, 2'b00, 32'd0, 1'b1);

    // Half loads that stay inside one word
    push_beat(1'b0, 32'h100, 4'hF, 32'd0, 32'h80011234);
    held = 32'hFFFF8001; push_res(2, 1'b0, held, 1);
    run_access("lh_102", 1'b1, 1'b0, 32'h102, 3'b101, 2'b00, 32'd0, 1'b1);
    push_beat(1'b0, 32'h200, 4'hF, 32'd0, 32'h00ABCD00);
    held = 32'h0000ABCD; push_res(2, 1'b0, held, 1);
    run_access("lhu_201", 1'b1, 1'b0, 32'h201, 3'b100, 2'b00, 32'd0, 1'b1);

    // Stores: half at offset 2, byte at offset 1 (load result held)
    push_beat(1'b1, 32'h300, 4'b1100, 32'hBEEF0000, 32'd0);
    push_res(2, 1'b0, held, 1);
    run_access("sh_302", 1'b0, 1'b1, 32'h302, 3'b000, 2'b10, 32'h0000BEEF, 1'b1);
    push_beat(1'b1, 32'h100, 4'b0010, 32'h3456A500, 32'd0);
    push_res(2, 1'b0, held, 1);
    run_access("sb_101", 1'b0, 1'b1, 32'h101, 3'b000, 2'b01, 32'h123456A5, 1'b1);

`ifdef LSU_MISALIGNED_EN
    // Split accesses: two beats, address wraps past the top of memory
    push_beat(1'b0, 32'h400, 4'hF, 32'd0, 32'h44332211);
    push_beat(1'b0, 32'h404, 4'hF, 32'd0, 32'h88776655);
    held = 32'h55443322; push_res(3, 1'b0, held, 2);
    run_access("lw_401", 1'b1, 1'b0, 32'h401, 3'b000, 2'b00, 32'd0, 1'b1);
    push_beat(1'b1, 32'hFFFFFFFC, 4'b1100, 32'hCCDD0000, 32'd0);
    push_beat(1'b1, 32'h00000000, 4'b0011, 32'h0000AABB, 32'd0);
    push_res(3, 1'b0, held, 2);
    run_access("sw_fffffffe", 1'b0, 1'b1, 32'hFFFFFFFE, 3'b000, 2'b00, 32'hAABBCCDD, 1'b1);
    push_beat(1'b0, 32'h200, 4'hF, 32'd0, 32'h7F000000);
    push_beat(1'b0, 32'h204, 4'hF, 32'd0, 32'h000000C3);
    held = 32'hFFFFC37F; push_res(3, 1'b0, held, 2);
    run_access("lh_203", 1'b1, 1'b0, 32'h203, 3'b101, 2'b00, 32'd0, 1'b1);
`else
    // Split-class accesses fault without touching the bus
    push_res(1, 1'b1, held, 0);
    run_access("lw_401", 1'b1, 1'b0, 32'h401, 3'b000, 2'b00, 32'd0, 1'b1);
    push_res(1, 1'b1, held, 0);
    run_access("sw_fffffffe", 1'b0, 1'b1, 32'hFFFFFFFE, 3'b000, 2'b00, 32'hAABBCCDD, 1'b1);
    push_res(1, 1'b1, held, 0);
    run_access("lh_203", 1'b1, 1'b0, 32'h203, 3'b101, 2'b00, 32'd0, 1'b1);
`endif

    // Illegal requests fault immediately
    push_res(1, 1'b1, held, 0);
    run_access("bad_lt", 1'b1, 1'b0, 32'h100, 3'b011, 2'b00, 32'd0, 1'b1);
    push_res(1, 1'b1, held, 0);
    run_access("bad_st", 1'b0, 1'b1, 32'h100, 3'b000, 2'b11, 32'd0, 1'b1);
    push_res(1, 1'b1, held, 0);
    run_access("rd_and_wr", 1'b1, 1'b1, 32'h100, 3'b000, 2'b00, 32'd0, 1'b1);

    // No ack: request held for TIMEOUT cycles, then fault with data held
    push_res(5, 1'b1, held, 4);
    run_access("timeout", 1'b1, 1'b0, 32'h500, 3'b000, 2'b00, 32'd0, 1'b0);

    // Reset in the middle of a beat clears outputs at once
    @(negedge clk);
    i_MemRead = 1'b1; i_Addr = 32'h600; i_LoadType = 3'b000;
    @(negedge clk);
    @(negedge clk);
    check("midrst:req_before", 32'(o_BusReq), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst:req", 32'(o_BusReq), 32'd0);
    check("midrst:addr", o_BusAddr, 32'd0);
    check("midrst:rdata", o_ReadDataOut, 32'd0);
    i_MemRead = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst:idle_req", 32'(o_BusReq), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
